// File: rtl/two_of_five_tx_if.sv
// Digit handshake and serial-line bundle for the 2-of-5 transmitter.
// master = digit source / line observer, slave = transmitter.
interface two_of_five_tx_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       digit;
    logic             digit_valid;
    logic             digit_ready;
    logic             out;
    logic             sync;
    logic             data_slot;
    logic             err;
    logic [CNT_W-1:0] sent_count;

    modport master (
        output digit, digit_valid,
        input  digit_ready, out, sync, data_slot, err, sent_count
    );

    modport slave (
        input  digit, digit_valid,
        output digit_ready, out, sync, data_slot, err, sent_count
    );
endinterface

// File: rtl/two_of_five_tx.sv
// Serial 2-of-5 (7-4-2-1-0) transmitter: one digit per fixed 5-cycle slot,
// slots aligned to reset, FILL word in idle or invalid-digit slots.
module two_of_five_tx #(
    parameter int         MSB_FIRST = 1,
    parameter logic [4:0] FILL      = 5'b00000,
    parameter int         CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    two_of_five_tx_if.slave  bus
);
    localparam logic W_FILL_FIRST = (MSB_FIRST != 0) ? FILL[4] : FILL[0];

    logic [2:0]       r_slot;
    logic [4:0]       r_shift;
    logic             r_out;
    logic             r_data;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic [2:0]       w_slot_nx;
    logic [4:0]       w_shift_nx;
    logic             w_out_nx;
    logic             w_data_nx;
    logic             w_err_nx;
    logic [CNT_W-1:0] w_cnt_nx;

    logic             w_last;
    logic             w_acc;
    logic             w_ok;
    logic [4:0]       w_code;
    logic [4:0]       w_word;
    logic [4:0]       w_src;

    always_comb begin
        w_code = FILL;
        case (bus.digit)
            4'd0: w_code = 5'b11000;
            4'd1: w_code = 5'b00011;
            4'd2: w_code = 5'b00101;
            4'd3: w_code = 5'b00110;
            4'd4: w_code = 5'b01001;
            4'd5: w_code = 5'b01010;
            4'd6: w_code = 5'b01100;
            4'd7: w_code = 5'b10001;
            4'd8: w_code = 5'b10010;
            4'd9: w_code = 5'b10100;
            default: w_code = FILL;
        endcase
    end

    assign w_last = (r_slot == 3'd4);
    assign w_ok   = (bus.digit <= 4'd9);
    assign w_acc  = w_last & bus.digit_valid;
    assign w_word = (w_acc & w_ok) ? w_code : FILL;
    // On the slot boundary the first bit leaves straight from the new word.
    assign w_src  = w_last ? w_word : r_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot  <= 3'd4;
            r_shift <= FILL;
            r_out   <= W_FILL_FIRST;
            r_data  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_slot  <= w_slot_nx;
            r_shift <= w_shift_nx;
            r_out   <= w_out_nx;
            r_data  <= w_data_nx;
            r_err   <= w_err_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_slot_nx  = r_slot + 3'd1;
        w_data_nx  = r_data;
        w_err_nx   = 1'b0;
        w_cnt_nx   = r_cnt;
        w_out_nx   = w_src[0];
        w_shift_nx = {1'b0, w_src[4:1]};
        if (MSB_FIRST != 0) begin
            w_out_nx   = w_src[4];
            w_shift_nx = {w_src[3:0], 1'b0};
        end
        if (w_last) begin
            w_slot_nx = 3'd0;
            w_data_nx = w_acc & w_ok;
            w_err_nx  = w_acc & ~w_ok;
            if (w_acc & w_ok)
                w_cnt_nx = r_cnt + 1'b1;
        end
    end

    always_comb begin
        bus.digit_ready = w_last;
        bus.out         = r_out;
        bus.sync        = (r_slot == 3'd0);
        bus.data_slot   = r_data;
        bus.err         = r_err;
        bus.sent_count  = r_cnt;
    end
endmodule
